// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX pin between two byte requesters.
// Round-robin grant per frame, followed by an internal 8N1 serializer.
// Optional feature macro: UART_ARB_BURST_EN. When it is defined, the
// previous owner keeps the grant for up to MAX_BURST back-to-back frames.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic       io_mainClk,
  input  logic       io_reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || MAX_BURST < 1) begin : g_param_check
    $error("uart_tx_arbiter: CLKS_PER_BIT must be >= 2 and MAX_BURST >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          win1;
  logic          accept;
  logic          cnt_wrap;

`ifdef UART_ARB_BURST_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  logic [BW-1:0] burst_q, burst_d;
`endif

  // Arbitration: choose the winning requester and form the one-cycle accept strobe.
  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef UART_ARB_BURST_EN
      // burst_q == 0 means no frame since reset, so plain round-robin applies
      if (burst_q != '0 && burst_q < BURST_MAX) win1 = last_q;
      else                                      win1 = ~last_q;
`else
      win1 = ~last_q;
`endif
    end else begin
      win1 = req1_valid;
    end
    accept = (state_q == IDLE) && (req0_valid || req1_valid) && !io_reset;
  end

  assign req0_ready = accept && !win1;
  assign req1_ready = accept && win1;
  assign cnt_wrap   = (cnt_q == CNT_LAST);

  // Next-state logic for the serializer FSM, bit timing and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef UART_ARB_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (accept) begin
          shift_d = win1 ? req1_data : req0_data;
          grant_d = win1;
          last_d  = win1;
          txd_d   = 1'b0;
          state_d = START;
`ifdef UART_ARB_BURST_EN
          if (burst_q != '0 && win1 == last_q)
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
          else
            burst_d = BW'(1);
`endif
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_wrap) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_wrap) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_wrap) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset wins over any same-cycle request.
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
`ifdef UART_ARB_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef UART_ARB_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned CPB   = 4;
  localparam int unsigned MB    = 2;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       io_reset, req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, txd, busy, grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .MAX_BURST(MB)) dut (
    .io_mainClk(clk), .io_reset(io_reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .txd(txd), .busy(busy), .grant_id(grant_id)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 1'b0;
  bit          acc0 = 1'b0, acc1 = 1'b0;

  // Reference model: cycles elapsed since the last accept (0 = line idle).
  int         m_since = 0;
  int         m_last  = 1;
  int         m_grant = 0;
  int         m_burst = 0;
  logic [7:0] m_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (!req0_valid && !req1_valid) return -1;
    if (req0_valid != req1_valid) return req1_valid ? 1 : 0;
`ifdef UART_ARB_BURST_EN
    if (m_burst != 0 && m_burst < MB) return m_last;
`endif
    return 1 - m_last;
  endfunction

  // Line level k cycles into a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_txd(input int since, input logic [7:0] d);
    int slot;
    if (since == 0) return 1'b1;
    slot = (since - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  // Compare DUT against the model every cycle, then advance the model past the next edge.
  always @(negedge clk) begin
    int w;
    bit e0, e1;
    if (chk_en) begin
      w  = winner();
      e0 = (m_since == 0) && !io_reset && (w == 0);
      e1 = (m_since == 0) && !io_reset && (w == 1);
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("txd", txd, exp_txd(m_since, m_data));
      check("busy", busy, m_since != 0);
      check("grant_id", grant_id, m_grant[0]);
      acc0 = e0;
      acc1 = e1;
      if (io_reset) begin
        m_since = 0; m_last = 1; m_grant = 0; m_burst = 0;
      end else if (e0 || e1) begin
        m_data  = e1 ? req1_data : req0_data;
        m_burst = (m_burst != 0 && w == m_last) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
        m_last  = w;
        m_grant = w;
        m_since = 1;
      end else if (m_since != 0) begin
        m_since = (m_since == FRAME) ? 0 : m_since + 1;
      end
    end
  end

  task automatic wait_any(input int budget, output int id, output int t);
    bit ok;
    ok = 1'b0; id = -1; t = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        id = req1_ready ? 1 : 0;
        t  = int'($time / 10);
      end
    end
    check("wait_accept", ok, 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    io_reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 io_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int id, t, bcnt, r1, lows;
    int ts [6];
    int exp_ids [6];
    logic [39:0] trace;
`ifdef UART_ARB_BURST_EN
    exp_ids = '{0, 0, 1, 1, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1, 0, 1};
`endif
    io_reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 io_reset = 1'b0;

    // Idle after reset: line high, nothing granted.
    bcnt = 0; lows = 0; r1 = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (!txd) lows++;
      if (req0_ready || req1_ready) r1++;
    end
    check("idle_busy_cycles", bcnt, 0);
    check("idle_txd_low_cycles", lows, 0);
    check("idle_ready_count", r1, 0);

    // Single 0xA5 frame from requester 0.
    @(posedge clk); #1 req0_data = 8'hA5; req0_valid = 1'b1;
    wait_any(10, id, t);
    check("a5_owner", id, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    trace = '0; bcnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      trace[i] = txd;
      if (busy) bcnt++;
    end
    check("a5_trace", trace, 40'hFF0F00F0F0);
    check("a5_busy_cycles", bcnt, FRAME);
    check("a5_grant_id", grant_id, 0);
    @(negedge clk);
    check("a5_busy_after", busy, 0);
    check("a5_txd_after", txd, 1);

    // Both requesters continuously valid: grant order and accept spacing.
    do_reset(2);
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_any(FRAME + 5, id, ts[k]);
      check("contend_owner", id, exp_ids[k]);
      if (k > 0) check("contend_spacing", ts[k] - ts[k-1], FRAME + 1);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 2) @(posedge clk);

    // Reset and valid in the same idle cycle: no accept.
    #1 io_reset = 1'b1; req1_valid = 1'b1; req1_data = 8'h5A;
    @(negedge clk);
    check("rst_valid_ready1", req1_ready, 0);
    @(posedge clk); #1 io_reset = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("rst_valid_busy", busy, 0);

    // Reset mid-frame drops the byte; next contention goes to requester 0.
    @(posedge clk); #1 req0_data = 8'hA5; req0_valid = 1'b1;
    wait_any(10, id, t);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 io_reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("midrst_ready0", req0_ready, 0);
    check("midrst_ready1", req1_ready, 0);
    @(posedge clk); #1 io_reset = 1'b0;
    @(negedge clk);
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_next_owner0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 2) @(posedge clk);

    // Requester 1 withdraws before the line frees up: never granted.
    #1 req0_data = 8'hC3; req0_valid = 1'b1;
    wait_any(10, id, t);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 req1_valid = 1'b1; req1_data = 8'h3C;
    r1 = 0; lows = 0;
    repeat (20) begin @(negedge clk); if (req1_ready) r1++; end
    @(posedge clk); #1 req1_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req1_ready) r1++;
      if (i >= 20 && !txd) lows++;
    end
    check("withdraw_ready1_count", r1, 0);
    check("withdraw_txd_low_cycles", lows, 0);

    // Random traffic obeying the hold rule, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      io_reset = ($urandom_range(0, 499) == 0);
      if (req0_valid) begin
        if (acc0) begin
          if ($urandom_range(0, 1) == 1) req0_data = 8'($urandom);
          else req0_valid = 1'b0;
        end else if ($urandom_range(0, 49) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end
      if (req1_valid) begin
        if (acc1) begin
          if ($urandom_range(0, 1) == 1) req1_data = 8'($urandom);
          else req1_valid = 1'b0;
        end else if ($urandom_range(0, 49) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1; req1_data = 8'($urandom);
      end
    end
    @(posedge clk); #1 io_reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (FRAME + 5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmit pin between two byte-stream requesters, e.g. the Murax SoC UART and a board-level status/debug reporter.
- Round-robin arbitration at frame granularity; a grant is never revoked mid-frame.
- Contains its own 8N1 serializer and runs in the divided 50 MHz SoC clock domain.
- The board top level drives its UART TX pin from txd.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- MAX_BURST, 4, maximum back-to-back frames one requester may hold the grant; used only with UART_ARB_BURST_EN; legal range >= 1.

Ports:
- io_mainClk  input  1  sole clock, rising edge.
- io_reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a byte pending.
- req0_data  input  8  requester 0 byte; held stable while req0_valid is high and the byte is unaccepted.
- req0_ready  output  1  requester 0 byte accepted this cycle.
- req1_valid  input  1  requester 1 has a byte pending.
- req1_data  input  8  requester 1 byte; same hold rule as req0_data.
- req1_ready  output  1  requester 1 byte accepted this cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  frame in progress (state != IDLE).
- grant_id  output  1  owner of the current or most recent frame.

Behaviour:
- Reset values:
  - txd=1, busy=0, grant_id=0, req*_ready=0.
  - state=IDLE, last_grant=1, so requester 0 wins the first contention.
  - Bit counter, cycle counter and shift register cleared.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE arbitration:
  - Winner is the valid requester. If both are valid, the winner is !last_grant.
  - reqN_ready is asserted combinationally, for exactly one cycle, in IDLE when N is the winner.
  - On valid & ready: latch data into the shift register, set grant_id = last_grant = N, go to START next cycle.
  - Neither valid: stay in IDLE, txd=1.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit index counts 0..7, then go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing:
  - One frame = 10*CLKS_PER_BIT cycles after the accept cycle.
  - Minimum spacing between accepts is 10*CLKS_PER_BIT+1 cycles, since IDLE always lasts at least 1 cycle.
- txd is registered; it changes on the cycle boundary where state or bit advances.
- Cycle counter width is clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1, and the bit/state advances on that same edge.
- While busy=1: both ready outputs stay 0, and valid changes from either requester are ignored.
- A requester deasserting valid before acceptance is legal; it is simply not granted.
- Reset asserted mid-frame: on the next edge txd=1, state=IDLE, last_grant=1. The partially sent byte is dropped and no ready is asserted in that cycle.
- Reset and valid in the same cycle: reset wins, no accept.

Optional Feature:
- Macro: UART_ARB_BURST_EN.
- Defined:
  - In IDLE, if the previous owner is valid and burst_cnt < MAX_BURST, the previous owner wins even when the other requester is valid.
  - burst_cnt increments on each accept by the same owner and resets to 1 on an owner change.
  - Once MAX_BURST frames have been sent, the other requester wins if valid.
  - burst_cnt resets to 0.
- Undefined:
  - Strict round-robin as above; MAX_BURST is ignored and no burst counter is synthesized.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle 50 cycles -> txd=1, busy=0, ready=0 throughout.
- req0 sends 0xA5 alone -> req0_ready pulses 1 cycle. txd then shows 0 (4 cycles), bits 1,0,1,0,0,1,0,1 (4 cycles each), 1 (4 cycles). busy high for 40 cycles, grant_id=0.
- Both valid continuously (req0=0x11, req1=0x22), macro off -> accepts alternate 0,1,0,1. Accepts are 41 cycles apart, and req0 is granted first after reset.
- Reset asserted at cycle 15 of a frame -> next cycle txd=1, busy=0, state IDLE. The next contention is granted to req0.
- req1 valid, drops valid before the previous frame ends -> no req1_ready, no frame; txd stays 1.
- UART_ARB_BURST_EN, MAX_BURST=2, both valid continuously -> grant sequence 0,0,1,1,0,0. burst_cnt resets to 1 on each owner change.
